// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bus widths and ACK levels.
// Also provides the address-match rule used in the address phase.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK,
    IGNORE
  } i2c_tgt_state_e;

  // General call (address 0) never matches, even if own address were 0.
  function automatic logic addr_match(input logic [I2C_DATA_W-1:0] addr_byte,
                                      input logic [I2C_ADDR_W-1:0] own);
    return (addr_byte[7:1] == own) && (addr_byte[7:1] != '0);
  endfunction

endpackage

// File: rtl/i2c_bus_sync_edge.sv
// SCL/SDA synchronizers with one delay flop for edge and START/STOP detection.
// Events are valid SYNC_STAGES+1 cycles after the pad change (registered by the consumer).
module i2c_bus_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl;

  // Idle bus is high; resetting to 1 avoids a false edge when reset lifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl       = scl_sync[SYNC_STAGES-1];
  assign sda       = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_target_responder.sv
// Single-address I2C target: 7-bit addressing, byte writes and reads, open-drain SDA.
// Never stretches SCL; received bytes strobe out, transmit bytes are fetched on tx_req.
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'b1010101,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [I2C_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [I2C_DATA_W-1:0] tx_data,
  output logic                  tx_req,
  output logic                  rw_dir,
  output logic                  busy
);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_e        state, state_nxt;
  logic [2:0]            bit_cnt, bit_cnt_nxt;
  logic [I2C_DATA_W-1:0] shift, shift_nxt, byte_in;
  logic [I2C_DATA_W-1:0] rx_data_nxt;
  logic                  rw_nxt, rx_valid_nxt, sda_oe_nxt, busy_nxt;

  assign byte_in = {shift[I2C_DATA_W-2:0], sda};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      rw_dir   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      rw_dir   <= rw_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      sda_oe   <= sda_oe_nxt;
      busy     <= busy_nxt;
    end
  end

  // In the ACK states sda_oe doubles as the phase flag: low = waiting for the
  // fall that starts our ACK, high = waiting for the fall that ends it.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    rw_nxt       = rw_dir;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    sda_oe_nxt   = sda_oe;
    busy_nxt     = busy;
    tx_req       = 1'b0;

    if (stop_det) begin
      state_nxt   = IDLE;
      busy_nxt    = 1'b0;
      sda_oe_nxt  = 1'b0;
      bit_cnt_nxt = '0;
    end else if (start_det) begin
      state_nxt   = ADDR;
      busy_nxt    = 1'b1;
      sda_oe_nxt  = 1'b0;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (addr_match(byte_in, TARGET_ADDR)) begin
                state_nxt = ADDR_ACK;
                rw_nxt    = byte_in[0];
              end else begin
                state_nxt = IGNORE;
              end
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
              if (rw_dir) begin
                tx_req    = 1'b1;
                shift_nxt = tx_data;
              end
            end else if (rw_dir) begin
              state_nxt  = TX_DATA;
              sda_oe_nxt = ~shift[I2C_DATA_W-1];
            end else begin
              state_nxt  = RX_DATA;
              sda_oe_nxt = 1'b0;
            end
          end
        end

        RX_DATA: begin
          if (scl_rise) begin
            shift_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_nxt  = byte_in;
              rx_valid_nxt = 1'b1;
              state_nxt    = RX_ACK;
            end
          end
        end

        RX_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = RX_DATA;
            end
          end
        end

        // MSB is already on the bus at entry; each fall advances one bit.
        TX_DATA: begin
          if (scl_fall) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              sda_oe_nxt = 1'b0;
              state_nxt  = TX_ACK;
            end else begin
              shift_nxt  = {shift[I2C_DATA_W-2:0], 1'b0};
              sda_oe_nxt = ~shift[I2C_DATA_W-2];
            end
          end
        end

        TX_ACK: begin
          if (scl_rise && sda == I2C_NACK) begin
            state_nxt  = IGNORE;
            sda_oe_nxt = 1'b0;
          end else if (scl_fall) begin
            tx_req      = 1'b1;
            shift_nxt   = tx_data;
            sda_oe_nxt  = ~tx_data[I2C_DATA_W-1];
            bit_cnt_nxt = '0;
            state_nxt   = TX_DATA;
          end
        end

        IGNORE: sda_oe_nxt = 1'b0;

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench: a bit-banged I2C master drives the target through writes, reads,
// repeated START, truncated bytes and asynchronous reset.
module tb_i2c_target_responder;

  localparam int Q = 5;  // quarter SCL period in system clocks

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data;
    logic       exp_aack;
    logic       exp_dack;
    int         exp_rx;
    logic [7:0] exp_rx_data;
  } wvec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_oe, rx_valid, tx_req, rw_dir, busy;
  logic [7:0] rx_data, tx_data;
  wire        sda_bus = sda_m & ~sda_oe;

  int         n_chk = 0, n_pass = 0;
  int         rx_cnt = 0, tx_cnt = 0, oe_cnt = 0, busy_drop = 0;
  logic       watch_busy = 1'b0;
  logic [7:0] tx_vals [16];
  wvec_t      vec [6];

  always #5 clk = ~clk;

  i2c_target_responder #(.TARGET_ADDR(7'h55), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rw_dir   (rw_dir),
    .busy     (busy)
  );

  // tx_data advances only after the edge that consumed it.
  always @(negedge clk) begin
    if (tx_req) tx_cnt++;
    else        tx_data = tx_vals[tx_cnt % 16];
    if (rx_valid) rx_cnt++;
    if (sda_oe) oe_cnt++;
    if (watch_busy && !busy) busy_drop++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic seen);
    sda_m = b;  wait_q();
    scl = 1'b1; wait_q();
    seen = sda_bus; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic start_c();
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(ack_bit, s);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                          output logic aack, output logic dack, output logic busy_mid);
    start_c();
    send_byte(a, aack);
    busy_mid = busy;
    send_byte(d, dack);
    stop_c();
  endtask

  initial begin
    logic       aack, dack, bmid, s;
    logic [7:0] rd;
    int         rx0, tx0, oe0, bd0;

    vec[0] = '{8'hAA, 8'h55, 1'b1, 1'b1, 1, 8'h55};
    vec[1] = '{8'h54, 8'hA7, 1'b0, 1'b0, 0, 8'h55};
    vec[2] = '{8'h00, 8'hFF, 1'b0, 1'b0, 0, 8'h55};
    vec[3] = '{8'hAA, 8'h00, 1'b1, 1'b1, 1, 8'h00};
    vec[4] = '{8'hAE, 8'h12, 1'b0, 1'b0, 0, 8'h00};
    vec[5] = '{8'hAA, 8'hFE, 1'b1, 1'b1, 1, 8'hFE};
    for (int i = 0; i < 16; i++) tx_vals[i] = 8'h00;

    reset = 1'b1; scl = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_req", tx_req, 1'b0);
    chk("rst_rw_dir", rw_dir, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // Single-byte writes to matching and non-matching addresses
    for (int i = 0; i < 6; i++) begin
      rx0 = rx_cnt; oe0 = oe_cnt;
      do_write(vec[i].addr_byte, vec[i].data, aack, dack, bmid);
      repeat (2) @(negedge clk);
      chk($sformatf("w%0d_addr_ack", i), aack, vec[i].exp_aack);
      chk($sformatf("w%0d_data_ack", i), dack, vec[i].exp_dack);
      chk($sformatf("w%0d_rx_count", i), rx_cnt - rx0, vec[i].exp_rx);
      chk($sformatf("w%0d_rx_data", i), rx_data, vec[i].exp_rx_data);
      chk($sformatf("w%0d_oe_used", i), oe_cnt != oe0, vec[i].exp_aack);
      chk($sformatf("w%0d_busy_mid", i), bmid, 1'b1);
      chk($sformatf("w%0d_busy_end", i), busy, 1'b0);
    end

    // Two-byte read: master ACKs the first, NACKs the second
    tx0 = tx_cnt;
    tx_vals[tx_cnt % 16] = 8'hA5;
    tx_vals[(tx_cnt + 1) % 16] = 8'h3C;
    repeat (2) @(negedge clk);
    start_c();
    send_byte(8'hAB, aack);
    chk("rd_addr_ack", aack, 1'b1);
    chk("rd_rw_dir", rw_dir, 1'b1);
    read_byte(1'b0, rd);
    chk("rd_byte0", rd, 8'hA5);
    read_byte(1'b1, rd);
    chk("rd_byte1", rd, 8'h3C);
    chk("rd_nack_release", sda_oe, 1'b0);
    oe0 = oe_cnt;
    stop_c();
    repeat (2) @(negedge clk);
    chk("rd_tx_req_count", tx_cnt - tx0, 2);
    chk("rd_oe_after_nack", oe_cnt - oe0, 0);
    chk("rd_busy_end", busy, 1'b0);

    // Write, repeated START, read
    rx0 = rx_cnt;
    tx_vals[tx_cnt % 16] = 8'h81;
    repeat (2) @(negedge clk);
    start_c();
    bd0 = busy_drop;
    watch_busy = 1'b1;
    send_byte(8'hAA, aack);
    chk("rs_w_addr_ack", aack, 1'b1);
    chk("rs_w_rw_dir", rw_dir, 1'b0);
    send_byte(8'h12, dack);
    chk("rs_w_data_ack", dack, 1'b1);
    start_c();
    send_byte(8'hAB, aack);
    chk("rs_r_addr_ack", aack, 1'b1);
    chk("rs_r_rw_dir", rw_dir, 1'b1);
    read_byte(1'b1, rd);
    chk("rs_r_byte", rd, 8'h81);
    watch_busy = 1'b0;
    chk("rs_busy_held", busy_drop - bd0, 0);
    stop_c();
    repeat (2) @(negedge clk);
    chk("rs_rx_data", rx_data, 8'h12);
    chk("rs_rx_count", rx_cnt - rx0, 1);
    chk("rs_busy_end", busy, 1'b0);

    // STOP after four data bits of a write
    rx0 = rx_cnt;
    start_c();
    send_byte(8'hAA, aack);
    chk("part_addr_ack", aack, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(i[0], s);
    stop_c();
    repeat (2) @(negedge clk);
    chk("part_rx_count", rx_cnt - rx0, 0);
    chk("part_sda_oe", sda_oe, 1'b0);
    chk("part_busy", busy, 1'b0);
    chk("part_rx_data", rx_data, 8'h12);

    // Reset while the target drives the address ACK
    start_c();
    for (int i = 7; i >= 0; i--) send_bit(i[0] == 1'b1 ? 1'b1 : 1'b0, s);
    chk("arst_pre_oe", sda_oe, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_oe_async", sda_oe, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_rx_data", rx_data, 8'h00);
    scl = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = rx_cnt;
    do_write(8'hAA, 8'hC3, aack, dack, bmid);
    repeat (2) @(negedge clk);
    chk("post_addr_ack", aack, 1'b1);
    chk("post_data_ack", dack, 1'b1);
    chk("post_rx_data", rx_data, 8'hC3);
    chk("post_rx_count", rx_cnt - rx0, 1);
    chk("post_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- I2C target (slave) end of the bus driven by FSM_i2c_master; single-target, 7-bit addressing, byte-wide write and read.
- Oversamples SCL/SDA on the system clock. Pulls SDA low through an open-drain enable; never drives SCL (no clock stretching).
- Hands received bytes to the fabric as single-cycle strobes and fetches transmit bytes through a request strobe.

Parameters:
- TARGET_ADDR, 7'b1010101, own 7-bit address compared against the address phase.
- SYNC_STAGES, 2, synchronizer depth on scl_in and sda_in (minimum 2).

Ports:
- clk  input  1  system clock; at least 8x SCL rate.
- reset  input  1  asynchronous, active-high reset.
- scl_in  input  1  raw I2C SCL level from the pad.
- sda_in  input  1  raw I2C SDA level from the pad.
- sda_oe  output  1  1 = pull SDA low; 0 = release. The pad ties the output value to 0.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-cycle strobe; rx_data is valid in the same cycle.
- tx_data  input  8  byte returned on a read; sampled in the cycle tx_req is high.
- tx_req  output  1  one-cycle strobe requesting the next read byte.
- rw_dir  output  1  R/W bit of the current transfer (1 = read); held until the next address phase.
- busy  output  1  high from START until STOP.

Behaviour:
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, rw_dir=0, busy=0, FSM=IDLE, bit counter=0. Reset mid-transfer releases SDA immediately, because reset is asynchronous.
- Input conditioning:
  - SYNC_STAGES flops on each input, plus one delay flop for edge detection.
  - Events reach the FSM SYNC_STAGES+1 cycles after the pad change.
- Bus events:
  - scl_rise / scl_fall: synchronized SCL edges.
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - START/STOP take priority over any data edge detected in the same cycle.
- Data timing: SDA is sampled on scl_rise. sda_oe changes only on scl_fall, except that STOP, START and reset release it immediately.
- FSM states:
  - IDLE
    - START -> ADDR, busy=1, bit counter cleared.
  - ADDR
    - Shift 8 bits MSB-first.
    - After 8th scl_rise: if addr[7:1]==TARGET_ADDR -> ADDR_ACK and latch rw_dir=bit0; else -> IGNORE.
  - ADDR_ACK
    - On next scl_fall: sda_oe=1.
    - If rw_dir=1, pulse tx_req in that cycle and load the shift register from tx_data.
    - On the following scl_fall: go to RX_DATA (write) or TX_DATA (read). For TX_DATA, sda_oe = ~shift[7] in that cycle.
  - RX_DATA
    - Shift 8 bits.
    - After 8th scl_rise: rx_data updated and rx_valid pulses one cycle -> RX_ACK.
  - RX_ACK
    - ACK is unconditional: sda_oe=1 from the next scl_fall until the scl_fall after.
    - Then -> RX_DATA.
  - TX_DATA
    - On each scl_fall after bit 0 has been presented, present the next bit: sda_oe = ~bit, MSB first.
    - After the 8th bit's scl_fall: release SDA -> TX_ACK.
  - TX_ACK
    - Sample SDA on scl_rise.
    - ACK (0): on the next scl_fall, pulse tx_req, reload, present MSB -> TX_DATA.
    - NACK (1): -> IGNORE with SDA released.
  - IGNORE
    - sda_oe=0; wait for bus events only.
- Global transitions:
  - START from any non-IDLE state (repeated START) -> ADDR, SDA released, bit counter cleared, busy stays 1.
  - STOP from any state -> IDLE, busy=0, sda_oe=0. A partial byte is discarded with no rx_valid.
- Bit counter: 3 bits, wraps 7->0 at the end of each byte; 9th bit (ACK) is tracked by state.
- General call (address 0x00) is not acknowledged.

Decomposition:
- Package i2c_pkg:
  - state enum i2c_tgt_state_e {IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE}.
  - I2C_ADDR_W=7, I2C_DATA_W=8.
  - Constants I2C_ACK=1'b0 and I2C_NACK=1'b1.
- Sub-module i2c_bus_sync_edge: synchronizers plus scl_rise, scl_fall, start_det and stop_det outputs. Reused by any future I2C block.

Test Plan:
- Write 0x55 to address 0x55 (addr byte 0xAA) -> ACK on 9th clock; one rx_valid with rx_data=0x55; target ACKs the data byte; busy falls after STOP.
- Address 0x2A with TARGET_ADDR=0x55 -> sda_oe stays 0 for the whole transfer; no rx_valid; FSM returns to IDLE on STOP.
- Read from 0x55 (0xAB) with tx_data=0xA5, then master ACK, tx_data=0x3C, then master NACK, STOP:
  - Expect two tx_req pulses.
  - SDA bit sequence 10100101 00111100.
  - SDA released after the NACK.
- Write 0x12, repeated START, read with tx_data=0x81:
  - rx_data=0x12 and rw_dir=1 after the 2nd address.
  - busy stays 1 throughout.
  - Read returns 0x81.
- STOP after 4 data bits of a write -> no rx_valid; state IDLE; sda_oe=0.
- Assert reset while the target is driving ACK (sda_oe=1) -> sda_oe=0 in the same cycle without waiting for a clock edge. After release, a fresh write of 0xC3 completes normally.
